// File: rtl/hex_sched_pkg.sv
// rtl/hex_sched_pkg.sv - shared types and constants for the hex display scheduler
package hex_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_e;

    localparam logic [1:0]  DISP_NONE  = 2'b00;
    localparam logic [1:0]  DISP_A     = 2'b01;
    localparam logic [1:0]  DISP_B     = 2'b10;
    localparam logic [6:0]  BLANK_SEG  = 7'h7F;
    localparam logic [31:0] RESET_WORD = 32'h0000_FFFF;

    function automatic logic [1:0] state_to_sel(input state_e st);
        case (st)
            SHOW_A:  return DISP_A;
            SHOW_B:  return DISP_B;
            default: return DISP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - nibble to active-low seven-segment glyph, 0xF blanks the digit
module hex_seg_decode
    import hex_sched_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Segment order is {g,f,e,d,c,b,a}; a cleared bit lights the segment.
    always_comb begin
        seg = BLANK_SEG;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = BLANK_SEG;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - time-shares hex_0..hex_2 between two digit sources
// Optional macro HEX_SRC_INDICATOR_EN lights the rightmost DP while source B is shown.
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [23:0] a_digits,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [23:0] b_digits,
    output logic [31:0] hex_0,
    output logic [31:0] hex_1,
    output logic [31:0] hex_2,
    output logic [1:0]  disp_sel
);

    localparam int             CW     = $clog2(DWELL_CYCLES);
    localparam logic [CW-1:0]  RELOAD = CW'(DWELL_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    disp_sel_q, disp_sel_d;

    logic [23:0]   a_shadow_q, a_shadow_d, a_active_q, a_active_d;
    logic          a_pend_q, a_pend_d, a_loaded_q, a_loaded_d;
    logic [23:0]   b_shadow_q, b_shadow_d, b_active_q, b_active_d;
    logic          b_pend_q, b_pend_d, b_loaded_q, b_loaded_d;

    logic [31:0]   hex_0_q, hex_0_d, hex_1_q, hex_1_d, hex_2_q, hex_2_d;

    logic          a_acc, a_xfer, b_acc, b_xfer;
    logic [23:0]   show_digits;
    logic [6:0]    seg [6];
    logic          lo_dp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (a_pend_q) begin
                    state_d = SHOW_A;
                    cnt_d   = RELOAD;
                end else if (b_pend_q) begin
                    state_d = SHOW_B;
                    cnt_d   = RELOAD;
                end
            end
            SHOW_A: begin
                if (cnt_q == '0) begin
                    cnt_d = RELOAD;
                    if (b_loaded_q || b_pend_q) state_d = SHOW_B;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            SHOW_B: begin
                if (cnt_q == '0) begin
                    cnt_d = RELOAD;
                    if (a_loaded_q || a_pend_q) state_d = SHOW_A;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        disp_sel_d = state_to_sel(state_d);
    end

    // A pending shadow moves to active while its source is shown or on the edge it becomes shown.
    always_comb begin
        a_acc      = a_valid && !a_pend_q;
        a_xfer     = a_pend_q && (state_q == SHOW_A || state_d == SHOW_A);
        a_shadow_d = a_acc  ? a_digits   : a_shadow_q;
        a_active_d = a_xfer ? a_shadow_q : a_active_q;
        a_loaded_d = a_loaded_q || a_xfer;
        a_pend_d   = a_acc || (a_pend_q && !a_xfer);

        b_acc      = b_valid && !b_pend_q;
        b_xfer     = b_pend_q && (state_q == SHOW_B || state_d == SHOW_B);
        b_shadow_d = b_acc  ? b_digits   : b_shadow_q;
        b_active_d = b_xfer ? b_shadow_q : b_active_q;
        b_loaded_d = b_loaded_q || b_xfer;
        b_pend_d   = b_acc || (b_pend_q && !b_xfer);
    end

    always_comb begin
        case (state_q)
            SHOW_A:  show_digits = a_active_q;
            SHOW_B:  show_digits = b_active_q;
            default: show_digits = 24'hFF_FFFF;
        endcase
    end

    for (genvar i = 0; i < 6; i++) begin : g_dec
        hex_seg_decode u_dec (
            .nibble (show_digits[4*i +: 4]),
            .seg    (seg[i])
        );
    end

`ifdef HEX_SRC_INDICATOR_EN
    assign lo_dp = (state_q != SHOW_B);
`else
    assign lo_dp = 1'b1;
`endif

    always_comb begin
        hex_0_d = {16'h0000, 1'b1, seg[1], lo_dp, seg[0]};
        hex_1_d = {16'h0000, 1'b1, seg[3], 1'b1,  seg[2]};
        hex_2_d = {16'h0000, 1'b1, seg[5], 1'b1,  seg[4]};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            disp_sel_q <= DISP_NONE;
            a_shadow_q <= '0;
            a_active_q <= '0;
            a_pend_q   <= 1'b0;
            a_loaded_q <= 1'b0;
            b_shadow_q <= '0;
            b_active_q <= '0;
            b_pend_q   <= 1'b0;
            b_loaded_q <= 1'b0;
            hex_0_q    <= RESET_WORD;
            hex_1_q    <= RESET_WORD;
            hex_2_q    <= RESET_WORD;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            disp_sel_q <= disp_sel_d;
            a_shadow_q <= a_shadow_d;
            a_active_q <= a_active_d;
            a_pend_q   <= a_pend_d;
            a_loaded_q <= a_loaded_d;
            b_shadow_q <= b_shadow_d;
            b_active_q <= b_active_d;
            b_pend_q   <= b_pend_d;
            b_loaded_q <= b_loaded_d;
            hex_0_q    <= hex_0_d;
            hex_1_q    <= hex_1_d;
            hex_2_q    <= hex_2_d;
        end
    end

    assign a_ready  = !a_pend_q;
    assign b_ready  = !b_pend_q;
    assign disp_sel = disp_sel_q;
    assign hex_0    = hex_0_q;
    assign hex_1    = hex_1_q;
    assign hex_2    = hex_2_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// tb/tb_hex_display_scheduler.sv - directed self-checking bench for hex_display_scheduler
module tb_hex_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic [23:0] a_digits, b_digits;
    logic        a_ready, b_ready;
    logic [31:0] hex_0, hex_1, hex_2;
    logic [1:0]  disp_sel;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] W_FFFF = 32'h0000_FFFF;
    localparam logic [31:0] W_34   = 32'h0000_B099;
    localparam logic [31:0] W_12   = 32'h0000_F9A4;
    localparam logic [31:0] W_00   = 32'h0000_C0C0;
    localparam logic [31:0] W_01   = 32'h0000_C0F9;
`ifdef HEX_SRC_INDICATOR_EN
    localparam logic [31:0] W_42   = 32'h0000_9924;
`else
    localparam logic [31:0] W_42   = 32'h0000_99A4;
`endif

    hex_display_scheduler #(.DWELL_CYCLES(8)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_digits    (a_digits),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_digits    (b_digits),
        .hex_0       (hex_0),
        .hex_1       (hex_1),
        .hex_2       (hex_2),
        .disp_sel    (disp_sel)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    // Leaves the bench just after edge t+2 where A's accept was edge t.
    task automatic start_with_a(input logic [23:0] d);
        reset_pulse();
        a_valid  = 1'b1;
        a_digits = d;
        tick();
        a_valid  = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset_pulse();
        total++; if (hex_0 !== W_FFFF) $display("FAIL reset_hex_0 got %h want %h", hex_0, W_FFFF); else passed++;
        total++; if (hex_1 !== W_FFFF) $display("FAIL reset_hex_1 got %h want %h", hex_1, W_FFFF); else passed++;
        total++; if (hex_2 !== W_FFFF) $display("FAIL reset_hex_2 got %h want %h", hex_2, W_FFFF); else passed++;
        total++; if ({a_ready, b_ready} !== 2'b11) $display("FAIL reset_ready got %b want 11", {a_ready, b_ready}); else passed++;
        total++; if (disp_sel !== 2'b00) $display("FAIL reset_sel got %b want 00", disp_sel); else passed++;
    endtask

    task automatic test_a_first();
        reset_pulse();
        a_valid  = 1'b1;
        a_digits = 24'hFF_1234;
        tick();
        a_valid  = 1'b0;
        total++; if (a_ready !== 1'b0) $display("FAIL a_ready_low got %b want 0", a_ready); else passed++;
        total++; if (disp_sel !== 2'b00) $display("FAIL a_sel_t0 got %b want 00", disp_sel); else passed++;
        tick();
        total++; if (a_ready !== 1'b1) $display("FAIL a_ready_back got %b want 1", a_ready); else passed++;
        total++; if (disp_sel !== 2'b01) $display("FAIL a_sel_t1 got %b want 01", disp_sel); else passed++;
        total++; if (hex_0 !== W_FFFF) $display("FAIL a_hex0_t1 got %h want %h", hex_0, W_FFFF); else passed++;
        tick();
        total++; if (hex_0 !== W_34) $display("FAIL a_hex0 got %h want %h", hex_0, W_34); else passed++;
        total++; if (hex_1 !== W_12) $display("FAIL a_hex1 got %h want %h", hex_1, W_12); else passed++;
        total++; if (hex_2 !== W_FFFF) $display("FAIL a_hex2 got %h want %h", hex_2, W_FFFF); else passed++;
    endtask

    task automatic test_a_only_holds();
        start_with_a(24'hFF_1234);
        for (int i = 0; i < 24; i++) begin
            tick();
            total++;
            if (disp_sel !== 2'b01 || hex_0 !== W_34 || hex_1 !== W_12)
                $display("FAIL hold_%0d got sel=%b hex0=%h hex1=%h want sel=01 hex0=%h hex1=%h",
                         i, disp_sel, hex_0, hex_1, W_34, W_12);
            else passed++;
        end
    endtask

    task automatic test_b_mid_dwell();
        start_with_a(24'hFF_1234);
        b_valid  = 1'b1;
        b_digits = 24'h00_0042;
        tick();
        b_valid  = 1'b0;
        total++; if (b_ready !== 1'b0) $display("FAIL b_ready_low got %b want 0", b_ready); else passed++;
        repeat (5) tick();
        total++; if (b_ready !== 1'b0 || disp_sel !== 2'b01) $display("FAIL b_pre_switch got ready=%b sel=%b want 0/01", b_ready, disp_sel); else passed++;
        tick();
        total++; if (disp_sel !== 2'b10 || b_ready !== 1'b1) $display("FAIL b_switch got sel=%b ready=%b want 10/1", disp_sel, b_ready); else passed++;
        total++; if (hex_0 !== W_34) $display("FAIL b_hex_lag got %h want %h", hex_0, W_34); else passed++;
        tick();
        total++; if (hex_0 !== W_42) $display("FAIL b_hex0 got %h want %h", hex_0, W_42); else passed++;
        total++; if (hex_1 !== W_00 || hex_2 !== W_00) $display("FAIL b_hex12 got %h/%h want %h", hex_1, hex_2, W_00); else passed++;
        repeat (6) tick();
        total++; if (disp_sel !== 2'b10) $display("FAIL b_last_cycle got %b want 10", disp_sel); else passed++;
        tick();
        total++; if (disp_sel !== 2'b01) $display("FAIL b_back_to_a got %b want 01", disp_sel); else passed++;
        tick();
        total++; if (hex_0 !== W_34) $display("FAIL a_hex_again got %h want %h", hex_0, W_34); else passed++;
    endtask

    task automatic test_both_same_cycle();
        reset_pulse();
        a_valid  = 1'b1;
        a_digits = 24'hFF_FF01;
        b_valid  = 1'b1;
        b_digits = 24'h00_0042;
        tick();
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        total++; if ({a_ready, b_ready} !== 2'b00) $display("FAIL both_ready got %b want 00", {a_ready, b_ready}); else passed++;
        tick();
        total++; if (disp_sel !== 2'b01 || {a_ready, b_ready} !== 2'b10) $display("FAIL both_a_first got sel=%b ready=%b want 01/10", disp_sel, {a_ready, b_ready}); else passed++;
        tick();
        total++; if (hex_0 !== W_01) $display("FAIL both_a_hex0 got %h want %h", hex_0, W_01); else passed++;
        repeat (6) tick();
        total++; if (b_ready !== 1'b0 || disp_sel !== 2'b01) $display("FAIL both_hold got ready=%b sel=%b want 0/01", b_ready, disp_sel); else passed++;
        tick();
        total++; if (disp_sel !== 2'b10) $display("FAIL both_switch got %b want 10", disp_sel); else passed++;
        tick();
        total++; if (hex_0 !== W_42) $display("FAIL both_b_hex0 got %h want %h", hex_0, W_42); else passed++;
    endtask

    // Runs straight on from test_both_same_cycle, which leaves B on display.
    task automatic test_reset_mid();
        a_valid  = 1'b1;
        a_digits = 24'h12_3456;
        tick();
        a_valid  = 1'b0;
        total++; if (a_ready !== 1'b0 || disp_sel !== 2'b10) $display("FAIL rm_pending got ready=%b sel=%b want 0/10", a_ready, disp_sel); else passed++;
        rst      = 1'b1;
        a_valid  = 1'b1;
        b_valid  = 1'b1;
        tick();
        rst      = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        total++; if (hex_0 !== W_FFFF || hex_1 !== W_FFFF || hex_2 !== W_FFFF) $display("FAIL rm_hex got %h %h %h want %h", hex_0, hex_1, hex_2, W_FFFF); else passed++;
        total++; if ({a_ready, b_ready} !== 2'b11 || disp_sel !== 2'b00) $display("FAIL rm_ctrl got ready=%b sel=%b want 11/00", {a_ready, b_ready}, disp_sel); else passed++;
        tick();
        tick();
        total++; if (disp_sel !== 2'b00 || hex_0 !== W_FFFF) $display("FAIL rm_discard got sel=%b hex0=%h want 00/%h", disp_sel, hex_0, W_FFFF); else passed++;
    endtask

    initial begin
        rst      = 1'b1;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        a_digits = '0;
        b_digits = '0;
        test_reset();
        test_a_first();
        test_a_only_holds();
        test_b_mid_dwell();
        test_both_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hex_display_scheduler.md
# hex_display_scheduler

Time-shares the three seven-segment PIO words (hex_0..hex_2) between two digit producers: the game timer (source A) and the score keeper (source B). Each source hands over six BCD/hex nibbles through a valid/ready handshake into a shadow register. A dwell-timed scheduler alternates which source is shown, and a registered decode stage drives the active-low segment words toward the system's hex PIO inputs.

## Interface
- DWELL_CYCLES, 50_000_000, clock cycles each source stays on display; legal range ≥ 2
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- a_valid  in  1  source A offers a_digits
- a_ready  out  1  source A shadow free
- a_digits  in  24  six nibbles, [3:0] = rightmost digit
- b_valid  in  1  source B offers b_digits
- b_ready  out  1  source B shadow free
- b_digits  in  24  six nibbles, [3:0] = rightmost digit
- hex_0  out  32  digits 1:0
- hex_1  out  32  digits 3:2
- hex_2  out  32  digits 5:4
- disp_sel  out  2  00 none, 01 A, 10 B

## Operation
- Word format: bits [6:0] are the low digit segments and bit 7 is its DP; bits [14:8] are the high digit and bit 15 its DP; bits [31:16] are 0. Segments and DP are active-low.
- Nibble decode:
  - 0x0–0xE map to hex glyphs.
  - 0xF is blank (7'h7F).
- Per source:
  - Shadow register plus pending flag.
  - Active register plus loaded flag.
  - ready_x = !pending_x.
  - Handshake accepted on a clock edge where valid_x && ready_x. At that edge the shadow loads and pending is set.
- Shadow → active transfer (clears pending, sets loaded):
  - Occurs on the next edge if source x is currently displayed.
  - Otherwise occurs at the edge on which the scheduler switches to x.
- FSM states: IDLE, SHOW_A, SHOW_B.
  - IDLE → SHOW_A when A has pending data; otherwise → SHOW_B when B has pending data. A wins when both are pending. Entering a state performs that source's transfer.
  - SHOW_x: the dwell counter reloads to DWELL_CYCLES-1 on entry and decrements each cycle.
  - At 0, if the other source is loaded or pending, switch to it and reload the counter. Otherwise stay in SHOW_x and reload.
  - IDLE is never re-entered except via reset.
- Output stage: hex_0..2 are registered from the active register of the displayed source. In IDLE, all six digits are blank.
- Width rules: the dwell counter is $clog2(DWELL_CYCLES) bits, with no wrap beyond the reload.

## Timing
- Reset values:
  - hex_0/1/2 = 32'h0000_FFFF
  - a_ready = b_ready = 1
  - disp_sel = 00
  - State IDLE, all flags 0
- Reset mid-operation: the state clears on the first reset edge. A handshake in that cycle is discarded.
- Accept into the displayed source at edge t:
  - transfer at t+1
  - hex outputs show the new value after edge t+2
  - ready is low for exactly one cycle
- Accept into the non-displayed source: ready stays low until the switch edge. The new value appears on hex one edge after the switch.
- A second accept while pending is impossible, because ready is low.
- Accept on the same edge as a switch to that source: the shadow loads at that edge and transfers at the next edge, as for a displayed source.
- disp_sel changes on the switch edge. Hex words follow one cycle later.
- Each source is displayed for exactly DWELL_CYCLES cycles per turn.

## Configuration
- HEX_SRC_INDICATOR_EN:
  - Defined: while SHOW_B, hex_0 bit 7 (rightmost DP) is driven 0 (lit). It follows the same one-cycle output latency as the digits.
  - Undefined: all DP bits are constant 1 and the indicator logic is absent.

## Structure
- Package hex_sched_pkg holds:
  - state enum (IDLE, SHOW_A, SHOW_B)
  - disp_sel encodings
  - BLANK_SEG = 7'h7F
  - RESET_WORD = 32'h0000_FFFF
- Sub-module hex_seg_decode: combinational 4-bit nibble → 7-bit active-low segments, instantiated six times ahead of the output register.

## Test plan
All scenarios use DWELL_CYCLES = 8.
- Reset, then A sends 24'hFF_1234:
  - a_ready low for one cycle
  - disp_sel = 01
  - hex_1/hex_0 show "12"/"34"
  - hex_2 = 32'h0000_FFFF
- A loaded and B sends 24'h000042 mid-dwell:
  - b_ready stays low until the switch after 8 cycles of A
  - then disp_sel = 10 and "000042" is shown for 8 cycles
  - then back to A
- A and B both valid in the same cycle from IDLE:
  - SHOW_A first
  - b_ready held low until the switch
- Only A loaded: the state stays SHOW_A indefinitely, and the hex output is unchanged across dwell expiries.
- Reset asserted while SHOW_B with pending A: the next cycle returns to the reset values, and a handshake in the reset cycle is ignored.
- With HEX_SRC_INDICATOR_EN: hex_0[7] = 0 only during B display. Without it, hex_0[7] = 1 always.
